// File: rtl/uart_rx_cfg.sv
// Purpose: configurable UART receiver (5..9 data bits, none/odd/even parity, 1 or 2 stop bits).
// Latency: po_flag rises about 2 + MID cycles into the last stop bit; all result outputs are valid with it.
// Backpressure: none; each result is held until the next frame completes, and a missed po_flag pulse is not recoverable.
module uart_rx_cfg #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int UART_BPS  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_flag,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int CW           = $clog2(BAUD_CNT_MAX);
  localparam int MID          = BAUD_CNT_MAX / 2;

  localparam logic [CW-1:0] CNT_SAMP_A = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_SAMP_B = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC    = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(BAUD_CNT_MAX - 1);
  localparam logic [3:0]    LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP  = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD    = (PARITY == 1);

  // Reject configurations the sampling scheme cannot support.
  if (BAUD_CNT_MAX < 16) begin : g_baud_err
    $error("uart_rx_cfg: CLK_FREQ/UART_BPS must be at least 16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_cfg_err
    $error("uart_rx_cfg: illegal DATA_BITS/PARITY/STOP_BITS");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_DONE
  } state_t;

  state_t                 state, state_next;
  logic                   rx_s1, rx_s2, rx_s3;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_cnt;
  logic                   samp_a, samp_b;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_acc, stop_acc;
  logic                   maj, at_dec, bit_end, start_edge;

  assign maj        = (samp_a & samp_b) | (samp_a & rx_s3) | (samp_b & rx_s3);
  assign at_dec     = (cnt == CNT_DEC);
  assign bit_end    = (cnt == CNT_LAST);
  assign start_edge = (state == ST_IDLE) && !rx_s2 && rx_s3;
  assign po_flag    = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);

  // Two-flop synchroniser plus one delay stage for edge detection and sampling.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic; the last stop bit finishes at its decision point, not at bit end.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start_edge) state_next = ST_START;
      ST_START: begin
        if (at_dec && maj)  state_next = ST_IDLE;
        else if (bit_end)   state_next = ST_DATA;
      end
      ST_DATA:   if (bit_end && bit_cnt == LAST_DATA)
                   state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_next = ST_STOP;
      ST_STOP:   if (at_dec && bit_cnt == LAST_STOP) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Baud/bit counters, majority sampling, shift register and result registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt        <= '0;
      bit_cnt    <= '0;
      samp_a     <= 1'b0;
      samp_b     <= 1'b0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      stop_acc   <= 1'b0;
      po_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (state == ST_IDLE || state_next == ST_IDLE) cnt <= '0;
      else if (bit_end)                              cnt <= '0;
      else                                           cnt <= cnt + 1'b1;

      if (state_next != state) bit_cnt <= '0;
      else if (bit_end)        bit_cnt <= bit_cnt + 1'b1;

      if (cnt == CNT_SAMP_A) samp_a <= rx_s3;
      if (cnt == CNT_SAMP_B) samp_b <= rx_s3;

      if (state == ST_DATA && at_dec) shreg <= {maj, shreg[DATA_BITS-1:1]};

      if (state == ST_IDLE) begin
        par_acc  <= 1'b0;
        stop_acc <= 1'b0;
      end
      if (state == ST_PARITY && at_dec) par_acc <= ((^shreg) ^ maj) != PAR_ODD;
      if (state == ST_STOP && at_dec)   stop_acc <= stop_acc | ~maj;

      // Results are loaded on entry to DONE so they are valid alongside po_flag.
      if (state == ST_STOP && state_next == ST_DONE) begin
        po_data    <= shreg;
        parity_err <= par_acc;
        frame_err  <= stop_acc | ~maj;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Purpose: directed self-checking bench for uart_rx_cfg across four parameter sets.
// Latency: frames are driven bit-by-bit; results are checked after each frame ends.
// Backpressure: not applicable.
module tb_uart_rx_cfg;

  localparam int P_DEF  = 5208;  // 50 MHz / 9600
  localparam int P_FAST = 32;    // 3.2 MHz / 100 kbps

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_l [4];
  logic [7:0] data0, data1, data3;
  logic [6:0] data2;
  logic       flag0, flag1, flag2, flag3;
  logic       perr0, perr1, perr2, perr3;
  logic       ferr0, ferr1, ferr2, ferr3;
  logic       busy0, busy1, busy2, busy3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fcnt0 = 0, fcnt1 = 0, fcnt2 = 0, fcnt3 = 0;
  int fcyc0 = 0;
  int start_cyc, base;
  logic [7:0] q1 [$];

  always #5 clk = ~clk;

  uart_rx_cfg u_def (
    .sys_clk(clk), .sys_rst(rst), .rx(rx_l[0]), .po_data(data0), .po_flag(flag0),
    .parity_err(perr0), .frame_err(ferr0), .busy(busy0));

  uart_rx_cfg #(.CLK_FREQ(3_200_000), .UART_BPS(100_000)) u_fast (
    .sys_clk(clk), .sys_rst(rst), .rx(rx_l[1]), .po_data(data1), .po_flag(flag1),
    .parity_err(perr1), .frame_err(ferr1), .busy(busy1));

  uart_rx_cfg #(.CLK_FREQ(3_200_000), .UART_BPS(100_000), .DATA_BITS(7), .PARITY(2)) u_par (
    .sys_clk(clk), .sys_rst(rst), .rx(rx_l[2]), .po_data(data2), .po_flag(flag2),
    .parity_err(perr2), .frame_err(ferr2), .busy(busy2));

  uart_rx_cfg #(.CLK_FREQ(3_200_000), .UART_BPS(100_000), .STOP_BITS(2)) u_stp (
    .sys_clk(clk), .sys_rst(rst), .rx(rx_l[3]), .po_data(data3), .po_flag(flag3),
    .parity_err(perr3), .frame_err(ferr3), .busy(busy3));

  // Cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Flag monitor: counts pulses and logs received words.
  always @(negedge clk) begin
    if (flag0) begin fcnt0 = fcnt0 + 1; fcyc0 = cyc; end
    if (flag1) begin fcnt1 = fcnt1 + 1; q1.push_back(data1); end
    if (flag2) fcnt2 = fcnt2 + 1;
    if (flag3) fcnt3 = fcnt3 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives n bits (bit 0 first) on line idx, each for per cycles.
  task automatic send(input int idx, input logic [15:0] bits, input int n, input int per);
    for (int i = 0; i < n; i++) begin
      rx_l[idx] = bits[i];
      repeat (per) @(negedge clk);
    end
  endtask

  task automatic idle(input int idx, input int ncyc);
    rx_l[idx] = 1'b1;
    repeat (ncyc) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rx_l[i] = 1'b1;
    repeat (5) @(negedge clk);

    // Reset state
    chk("rst_data", {8'h0, data0, data1, 1'b0, data2}, 32'h0);
    chk("rst_data3", 32'(data3), 32'h0);
    chk("rst_flags", 32'({flag0, flag1, flag2, flag3, perr0, perr1, perr2, perr3}), 32'h0);
    chk("rst_ferr_busy", 32'({ferr0, ferr1, ferr2, ferr3, busy0, busy1, busy2, busy3}), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Back-to-back 8N1 frames, no idle gap
    q1.delete();
    send(1, {7'h0, 1'b1, 8'h00, 1'b0}, 10, P_FAST);
    send(1, {7'h0, 1'b1, 8'hFF, 1'b0}, 10, P_FAST);
    send(1, {7'h0, 1'b1, 8'h81, 1'b0}, 10, P_FAST);
    idle(1, 2 * P_FAST);
    chk("b2b_count", 32'(q1.size()), 32'd3);
    chk("b2b_d0", 32'((q1.size() > 0) ? q1[0] : 8'hxx), 32'h00);
    chk("b2b_d1", 32'((q1.size() > 1) ? q1[1] : 8'hxx), 32'hFF);
    chk("b2b_d2", 32'((q1.size() > 2) ? q1[2] : 8'hxx), 32'h81);
    chk("b2b_errs", 32'({perr1, ferr1}), 32'h0);

    // 7E1: 0x35 has four ones, correct even parity bit is 0; send it inverted
    send(2, {6'h0, 1'b1, 1'b1, 7'h35, 1'b0}, 10, P_FAST);
    idle(2, 2 * P_FAST);
    chk("par_bad_data", 32'(data2), 32'h35);
    chk("par_bad_perr", 32'(perr2), 32'h1);
    chk("par_bad_ferr", 32'(ferr2), 32'h0);
    send(2, {6'h0, 1'b1, 1'b0, 7'h35, 1'b0}, 10, P_FAST);
    idle(2, 2 * P_FAST);
    chk("par_ok_perr", 32'(perr2), 32'h0);
    chk("par_count", 32'(fcnt2), 32'd2);

    // 8N2 with second stop bit low, then line held low (break)
    send(3, {5'h0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11, P_FAST);
    repeat (100) @(negedge clk);
    chk("stp_break_busy", 32'(busy3), 32'h0);
    idle(3, 2 * P_FAST);
    chk("stp_data", 32'(data3), 32'h3C);
    chk("stp_ferr", 32'(ferr3), 32'h1);
    chk("stp_count", 32'(fcnt3), 32'd1);

    // Reset in the middle of data bit 4 (frame 0x96)
    base = fcnt1;
    send(1, {7'h0, 1'b1, 8'h96, 1'b0}, 5, P_FAST);
    rx_l[1] = 1'b1;
    repeat (P_FAST / 2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_data", 32'(data1), 32'h0);
    chk("mid_rst_errs", 32'({perr1, ferr1}), 32'h0);
    chk("mid_rst_busy", 32'(busy1), 32'h0);
    repeat (400) @(negedge clk);
    chk("mid_rst_noflag", 32'(fcnt1), 32'(base));
    send(1, {7'h0, 1'b1, 8'h5A, 1'b0}, 10, P_FAST);
    idle(1, 2 * P_FAST);
    chk("post_rst_data", 32'(data1), 32'h5A);
    chk("post_rst_count", 32'(fcnt1), 32'(base + 1));
    chk("post_rst_errs", 32'({perr1, ferr1}), 32'h0);

    // Default configuration: 8N1 frame 0xA5
    start_cyc = cyc;
    send(0, {7'h0, 1'b1, 8'hA5, 1'b0}, 10, P_DEF);
    idle(0, 100);
    chk("a5_count", 32'(fcnt0), 32'd1);
    chk("a5_data", 32'(data0), 32'hA5);
    chk("a5_errs", 32'({perr0, ferr0}), 32'h0);
    chk("a5_latency", 32'((fcyc0 - start_cyc >= 49472) && (fcyc0 - start_cyc <= 49488)), 32'h1);

    // 1000-cycle glitch on the default line
    rx_l[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_busy_hi", 32'(busy0), 32'h1);
    repeat (990) @(negedge clk);
    idle(0, 3000);
    chk("glitch_busy_lo", 32'(busy0), 32'h0);
    chk("glitch_noflag", 32'(fcnt0), 32'd1);
    chk("glitch_data", 32'(data0), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
